// File: rtl/psum_drain.sv
// psum_drain: accumulates per-filter psum snapshots across channel passes, then streams saturated results one lane per beat.
// Latency: a load with last=1 raises out_valid on the next cycle; one beat per cycle while out_ready is high.
// Backpressure: a beat holds data/idx/last while out_ready is low; loads arriving during the drain are dropped with an err pulse.
// Build option PSUM_RELU_EN: when defined, negative results are emitted as zero (accumulators keep the signed sum).
module psum_drain #(
    parameter int DW    = 16,
    parameter int MAX_P = 24,
    parameter int ACC_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                last,
    input  logic [4:0]          p,
    input  logic [MAX_P*DW-1:0] d_in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [4:0]          out_idx,
    output logic                out_last,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    localparam logic [4:0]              MAX_P5  = 5'(MAX_P);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DW-1:0]           OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]           OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [MAX_P];
    logic [4:0]              p_lat_q;
    logic [4:0]              idx_q;
    logic                    err_q, err_d;

    logic                    p_ok;
    logic                    xfer;
    logic                    final_beat;
    logic [4:0]              lane_lim;
    logic [MAX_P-1:0]        lane_en;
    logic signed [ACC_W-1:0] lane_ext [MAX_P];
    logic signed [ACC_W-1:0] acc_sel;
    logic [DW-1:0]           sat_val;

    assign p_ok       = (p != 5'd0) && (p <= MAX_P5);
    assign xfer       = (state_q == S_DRAIN) && out_ready;
    assign final_beat = (idx_q == (p_lat_q - 5'd1));
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;

    // Sign-extend each lane and decide which lanes take part in this load
    // (the incoming p on the first pass, the latched p afterwards).
    always_comb begin
        lane_lim = (state_q == S_IDLE) ? p : p_lat_q;
        for (int i = 0; i < MAX_P; i++) begin
            lane_ext[i] = {{(ACC_W-DW){d_in[i*DW+DW-1]}}, d_in[i*DW +: DW]};
            lane_en[i]  = (5'(i) < lane_lim);
        end
    end

    // State, latched lane count, drain index and err pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_lat_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && load && p_ok) begin
                p_lat_q <= p;
            end
            if (xfer) begin
                idx_q <= final_beat ? 5'd0 : idx_q + 5'd1;
            end
        end
    end

    // Next state and err; loads in DRAIN are never accepted, including on the final beat.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (p_ok) state_d = last ? S_DRAIN : S_ACCUM;
                    else      err_d   = 1'b1;
                end
            end
            S_ACCUM: begin
                if (load) begin
                    err_d = (p != p_lat_q);
                    if (last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                err_d = load;
                if (xfer && final_beat) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulator bank: overwrite on the first pass, add on later passes, clear after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_P; i++) acc_q[i] <= '0;
        end else if (state_q == S_IDLE && load && p_ok) begin
            for (int i = 0; i < MAX_P; i++) acc_q[i] <= lane_en[i] ? lane_ext[i] : '0;
        end else if (state_q == S_ACCUM && load) begin
            for (int i = 0; i < MAX_P; i++) begin
                if (lane_en[i]) acc_q[i] <= acc_q[i] + lane_ext[i];
            end
        end else if (xfer && final_beat) begin
            for (int i = 0; i < MAX_P; i++) acc_q[i] <= '0;
        end
    end

    // Output beat: saturate the selected accumulator; all outputs are zero outside DRAIN.
    always_comb begin
        acc_sel = acc_q[idx_q];
        if (acc_sel > SAT_MAX)      sat_val = OUT_MAX;
        else if (acc_sel < SAT_MIN) sat_val = OUT_MIN;
        else                        sat_val = acc_sel[DW-1:0];
`ifdef PSUM_RELU_EN
        if (sat_val[DW-1]) sat_val = '0;
`endif
        out_valid = (state_q == S_DRAIN);
        out_data  = out_valid ? sat_val : '0;
        out_idx   = out_valid ? idx_q : 5'd0;
        out_last  = out_valid && final_beat;
    end

endmodule
